// File: rtl/rle_run_ctrl_pkg.sv
// Shared definitions for the RLE run controller: FSM encoding and default widths.
package rle_run_ctrl_pkg;

  // Controller states; encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2
  } rle_state_e;

  localparam int unsigned DefDataW  = 8;
  localparam int unsigned DefCntW   = 8;
  localparam int unsigned DefMaxRun = 255;

endpackage

// File: rtl/rle_run_counter.sv
// Run-length counter: load-one on a new symbol, saturating increment on a repeat.
module rle_run_counter
  import rle_run_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = DefCntW,
  parameter int unsigned MAX_RUN = DefMaxRun
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_one,
  input  logic             incr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_RUN);

  logic [CNT_W-1:0] cnt_q;

  // Count register; load-one wins over increment, increment stops at MaxCnt.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load_one) begin
      cnt_q <= CNT_W'(1);
    end else if (incr && (cnt_q != MaxCnt)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt = cnt_q;
  assign sat = (cnt_q == MaxCnt);

endmodule

// File: rtl/rle_run_ctrl.sv
// Run-length controller: tracks the current run and emits (symbol, count, last)
// pairs through a registered valid/ready output stage.
module rle_run_ctrl
  import rle_run_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned CNT_W   = DefCntW,
  parameter int unsigned MAX_RUN = DefMaxRun
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_symbol,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_last,
  input  logic              out_ready,
  output logic              ovf_evt,
  output logic              busy
);

  rle_state_e        state_q, state_d;
  logic [DATA_W-1:0] run_sym_q, run_sym_d;
  logic [CNT_W-1:0]  run_cnt;
  logic              run_sat;
  logic              cnt_load, cnt_incr;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_symbol_q;
  logic [CNT_W-1:0]  out_count_q;
  logic              out_last_q;
  logic              ovf_q, ovf_d;

  logic              push;
  logic [DATA_W-1:0] push_sym;
  logic [CNT_W-1:0]  push_cnt;
  logic              push_last;

  logic              out_free;
  logic              accept;
  logic              match;

  rle_run_counter #(
    .CNT_W   (CNT_W),
    .MAX_RUN (MAX_RUN)
  ) u_run_counter (
    .clock    (clock),
    .reset    (reset),
    .load_one (cnt_load),
    .incr     (cnt_incr),
    .cnt      (run_cnt),
    .sat      (run_sat)
  );

  // Output slot can take a new pair if empty or being drained this cycle.
  assign out_free = !out_valid_q || out_ready;
  assign in_ready = ((state_q == StIdle) || (state_q == StRun)) && out_free;
  assign accept   = in_valid && in_ready;
  assign match    = (in_data == run_sym_q);

  // Next-state, run update and push decode.
  always_comb begin
    state_d   = state_q;
    run_sym_d = run_sym_q;
    cnt_load  = 1'b0;
    cnt_incr  = 1'b0;
    push      = 1'b0;
    push_sym  = run_sym_q;
    push_cnt  = run_cnt;
    push_last = 1'b0;
    ovf_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          run_sym_d = in_data;
          cnt_load  = 1'b1;
          if (in_last) begin
            push      = 1'b1;
            push_sym  = in_data;
            push_cnt  = CNT_W'(1);
            push_last = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (accept) begin
          if (match && !run_sat) begin
            cnt_incr = 1'b1;
            if (in_last) begin
              push      = 1'b1;
              push_cnt  = run_cnt + CNT_W'(1);
              push_last = 1'b1;
              state_d   = StIdle;
            end
          end else begin
            // Close the current run and start a new one with this symbol.
            push      = 1'b1;
            run_sym_d = in_data;
            cnt_load  = 1'b1;
            ovf_d     = match;
            if (in_last) begin
              state_d = StFlush;
            end
          end
        end
      end
      StFlush: begin
        if (out_free) begin
          push      = 1'b1;
          push_last = 1'b1;
          state_d   = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM, run symbol, output pair register and overflow pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= StIdle;
      run_sym_q    <= '0;
      out_valid_q  <= 1'b0;
      out_symbol_q <= '0;
      out_count_q  <= '0;
      out_last_q   <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_sym_q <= run_sym_d;
      ovf_q     <= ovf_d;
      if (push) begin
        out_valid_q  <= 1'b1;
        out_symbol_q <= push_sym;
        out_count_q  <= push_cnt;
        out_last_q   <= push_last;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_symbol = out_symbol_q;
  assign out_count  = out_count_q;
  assign out_last   = out_last_q;
  assign ovf_evt    = ovf_q;
  assign busy       = (state_q != StIdle) || out_valid_q;

endmodule

// File: tb/tb_rle_run_ctrl.sv
// Directed self-checking bench for rle_run_ctrl.
module tb_rle_run_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_symbol;
  logic [7:0] out_count;
  logic       out_last;
  logic       out_ready = 1'b0;
  logic       ovf_evt;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [16:0] pairs[$];
  int          ovf_seen = 0;

  always #5 clock = ~clock;

  rle_run_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_symbol (out_symbol),
    .out_count  (out_count),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .ovf_evt    (ovf_evt),
    .busy       (busy)
  );

  // Inputs change just after posedge, so negedge sees what the next edge will use.
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) pairs.push_back({out_symbol, out_count, out_last});
    if (ovf_evt) ovf_seen++;
  end

  // Offer one symbol and return one posedge+1 after it is accepted.
  task automatic send(input logic [7:0] d, input logic l);
    int waits = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clock);
    while (!in_ready && waits < 50) begin
      @(negedge clock);
      waits++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL send_timeout: symbol %h not accepted, in_ready=%b want 1", d, in_ready);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_pair(input string name, input logic [16:0] exp_p);
    total++;
    if (!out_valid || {out_symbol, out_count, out_last} !== exp_p) begin
      bad++;
      $display("FAIL %s: got valid=%b pair=%h/%0d/%b want pair=%h/%0d/%b", name, out_valid,
               out_symbol, out_count, out_last, exp_p[16:9], exp_p[8:1], exp_p[0]);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic check_queue(input string name, input int idx, input logic [16:0] exp_p);
    logic [16:0] got;
    got = (pairs.size() > idx) ? pairs[idx] : 17'h0;
    total++;
    if (got !== exp_p) begin
      bad++;
      $display("FAIL %s[%0d]: got %h/%0d/%b want %h/%0d/%b", name, idx, got[16:9], got[8:1],
               got[0], exp_p[16:9], exp_p[8:1], exp_p[0]);
    end
  endtask

  task automatic check_size(input string name, input int want);
    total++;
    if (pairs.size() != want) begin
      bad++;
      $display("FAIL %s: got %0d pairs want %0d", name, pairs.size(), want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    #1;
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_ovf", ovf_evt, 1'b0);
    check_bit("reset_in_ready", in_ready, 1'b1);
    total++;
    if (out_count !== 8'd0 || out_symbol !== 8'd0) begin
      bad++;
      $display("FAIL reset_fields: got %h/%0d want 00/0", out_symbol, out_count);
    end
    step(1);
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    pairs.delete();
    send(8'hA5, 1'b0);
    send(8'hA5, 1'b0);
    send(8'hA5, 1'b0);
    send(8'h3C, 1'b1);
    check_pair("basic_first", {8'hA5, 8'd3, 1'b0});
    check_bit("basic_flush_in_ready", in_ready, 1'b0);
    step(1);
    check_pair("basic_flush", {8'h3C, 8'd1, 1'b1});
    step(1);
    check_bit("basic_idle_busy", busy, 1'b0);
    check_size("basic_count", 2);
  endtask

  task automatic test_overflow();
    int ovf_before;
    out_ready = 1'b1;
    pairs.delete();
    ovf_before = ovf_seen;
    for (int i = 0; i < 300; i++) begin
      send(8'h55, (i == 299));
      if (i == 255) begin
        check_pair("ovf_split", {8'h55, 8'd255, 1'b0});
        check_bit("ovf_pulse", ovf_evt, 1'b1);
      end
    end
    check_pair("ovf_tail", {8'h55, 8'd45, 1'b1});
    step(2);
    total++;
    if (ovf_seen - ovf_before != 1) begin
      bad++;
      $display("FAIL ovf_total: got %0d pulses want 1", ovf_seen - ovf_before);
    end
    check_size("ovf_count", 2);
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    pairs.delete();
    send(8'h00, 1'b1);
    check_pair("single_pair", {8'h00, 8'd1, 1'b1});
    check_bit("single_in_ready", in_ready, 1'b1);
    check_bit("single_busy_pending", busy, 1'b1);
    step(1);
    check_bit("single_busy_done", busy, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [16:0] exp_p [5];
    exp_p[0] = {8'h11, 8'd1, 1'b0};
    exp_p[1] = {8'h22, 8'd1, 1'b0};
    exp_p[2] = {8'h11, 8'd1, 1'b0};
    exp_p[3] = {8'h22, 8'd1, 1'b0};
    exp_p[4] = {8'h11, 8'd1, 1'b1};
    out_ready = 1'b0;
    pairs.delete();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h11;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      total++;
      if (in_ready !== 1'b0 || {out_symbol, out_count, out_last} !== exp_p[0]) begin
        bad++;
        $display("FAIL bp_hold: cycle %0d in_ready=%b pair=%h/%0d/%b want 0 11/1/0", i,
                 in_ready, out_symbol, out_count, out_last);
      end
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h11, 1'b1);
    step(3);
    check_size("bp_count", 5);
    for (int k = 0; k < 5; k++) check_queue("bp_seq", k, exp_p[k]);
  endtask

  task automatic test_midreset();
    out_ready = 1'b1;
    send(8'h44, 1'b0);
    for (int i = 0; i < 7; i++) send(8'h33, 1'b0);
    out_ready = 1'b0;
    send(8'h66, 1'b0);
    check_pair("mr_pending", {8'h33, 8'd7, 1'b0});
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    #1;
    check_bit("mr_out_valid", out_valid, 1'b0);
    check_bit("mr_busy", busy, 1'b0);
    check_bit("mr_in_ready", in_ready, 1'b1);
    pairs.delete();
    out_ready = 1'b1;
    send(8'h9A, 1'b1);
    step(2);
    check_size("mr_count", 1);
    check_queue("mr_seq", 0, {8'h9A, 8'd1, 1'b1});
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    pairs.delete();
    send(8'h12, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h7E;
    in_last  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      total++;
      if (in_ready !== 1'b0 || out_symbol !== 8'h12) begin
        bad++;
        $display("FAIL b2b_hold: cycle %0d in_ready=%b sym=%h want 0 12", i, in_ready,
                 out_symbol);
      end
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    send(8'h7E, 1'b1);
    check_pair("b2b_new", {8'h7E, 8'd1, 1'b1});
    step(2);
    check_size("b2b_count", 2);
    check_queue("b2b_seq", 0, {8'h12, 8'd1, 1'b1});
    check_queue("b2b_seq", 1, {8'h7E, 8'd1, 1'b1});
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_overflow();
    test_single();
    test_backpressure();
    test_midreset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
